// File: rtl/rnn_pkg.sv
// Shared definitions for the denoise RNN layer sequencer: FSM states,
// layer index constants and concat-mux select encodings.
package rnn_pkg;

  localparam int N_LAYERS = 6;

  localparam int L_DENSE1 = 0;
  localparam int L_GRU1   = 1;
  localparam int L_DENSE2 = 2;
  localparam int L_GRU2   = 3;
  localparam int L_GRU3   = 4;
  localparam int L_DENSE3 = 5;

  localparam logic [1:0] CAT_NONE    = 2'd0;
  localparam logic [1:0] CAT_NOISE   = 2'd1;
  localparam logic [1:0] CAT_DENOISE = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_D1,
    S_G1,
    S_PAR,
    S_G3,
    S_D3,
    S_OUT
  } seq_state_t;

  function automatic logic [N_LAYERS-1:0] layer_bit(input int idx);
    return N_LAYERS'(1) << idx;
  endfunction

endpackage

// File: rtl/rnn_layer_sequencer_if.sv
// Handshake bundle between the RNN layer sequencer (master) and the
// frame front-end, layer engines and gains consumer (slave).
interface rnn_layer_sequencer_if
  import rnn_pkg::*;
#(
  parameter int FRAME_CNT_W = 16
);

  logic                   frame_valid;
  logic                   frame_ready;
  logic                   clear_state;
  logic                   gru_clear;
  logic [N_LAYERS-1:0]    layer_start;
  logic [N_LAYERS-1:0]    layer_done;
  logic [1:0]             cat_sel;
  logic                   vad_valid;
  logic                   gains_valid;
  logic                   gains_ready;
  logic                   busy;
  logic                   err;
  logic [FRAME_CNT_W-1:0] frame_cnt;

  modport master (
    input  frame_valid, clear_state, layer_done, gains_ready,
    output frame_ready, gru_clear, layer_start, cat_sel, vad_valid,
           gains_valid, busy, err, frame_cnt
  );

  modport slave (
    output frame_valid, clear_state, layer_done, gains_ready,
    input  frame_ready, gru_clear, layer_start, cat_sel, vad_valid,
           gains_valid, busy, err, frame_cnt
  );

endinterface

// File: rtl/rnn_seq_watchdog.sv
// Per-state cycle watchdog for the layer sequencer; expires during the
// TIMEOUT_CYCLES-th cycle spent in one waiting state.
module rnn_seq_watchdog #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TIMEOUT_W      = 13
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_enable,
  input  logic i_restart,
  output logic o_expired
);

  logic [TIMEOUT_W-1:0] r_count;
  logic [TIMEOUT_W-1:0] w_count;

  // The entry cycle of a state counts as cycle zero regardless of stale count.
  assign w_count   = i_restart ? '0 : r_count;
  assign o_expired = i_enable && (w_count == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (!i_enable) begin
      r_count <= '0;
    end else begin
      r_count <= w_count + TIMEOUT_W'(1);
    end
  end

endmodule

// File: rtl/rnn_layer_sequencer.sv
// Per-frame scheduler for the denoise RNN layer engines.
// Optional watchdog abort enabled by defining RNN_SEQ_TIMEOUT_EN.
module rnn_layer_sequencer
  import rnn_pkg::*;
#(
  parameter int FRAME_CNT_W = 16
`ifdef RNN_SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TIMEOUT_W      = 13
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rnn_layer_sequencer_if.master bus
);

  seq_state_t             r_state;
  logic                   r_frame_ready;
  logic                   r_busy;
  logic                   r_gru_clear;
  logic                   r_vad_valid;
  logic                   r_gains_valid;
  logic                   r_pending;
  logic                   r_seen_d2;
  logic                   r_seen_g2;
  logic [N_LAYERS-1:0]    r_layer_start;
  logic [1:0]             r_cat_sel;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;

  logic                   w_armed;
  logic [N_LAYERS-1:0]    w_done;
  logic                   w_step;

  // Dones are ignored on the start cycle, which is the only cycle a start bit is high.
  always_comb begin
    w_armed = (r_layer_start == '0);
    w_done  = bus.layer_done & {N_LAYERS{w_armed}};
    w_step  = 1'b0;
    case (r_state)
      S_D1:    w_step = w_done[L_DENSE1];
      S_G1:    w_step = w_done[L_GRU1];
      S_PAR:   w_step = (r_seen_d2 || w_done[L_DENSE2]) && (r_seen_g2 || w_done[L_GRU2]);
      S_G3:    w_step = w_done[L_GRU3];
      S_D3:    w_step = w_done[L_DENSE3];
      default: w_step = 1'b0;
    endcase
  end

`ifdef RNN_SEQ_TIMEOUT_EN
  logic r_err;
  logic w_timed;
  logic w_timeout;

  assign w_timed = (r_state == S_D1) || (r_state == S_G1) || (r_state == S_PAR) ||
                   (r_state == S_G3) || (r_state == S_D3);

  rnn_seq_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMEOUT_W      (TIMEOUT_W)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_enable  (w_timed),
    .i_restart (!w_armed),
    .o_expired (w_timeout)
  );

  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_frame_ready <= 1'b1;
      r_busy        <= 1'b0;
      r_gru_clear   <= 1'b0;
      r_vad_valid   <= 1'b0;
      r_gains_valid <= 1'b0;
      r_pending     <= 1'b0;
      r_seen_d2     <= 1'b0;
      r_seen_g2     <= 1'b0;
      r_layer_start <= '0;
      r_cat_sel     <= CAT_NONE;
      r_frame_cnt   <= '0;
`ifdef RNN_SEQ_TIMEOUT_EN
      r_err         <= 1'b0;
`endif
    end else begin
      r_layer_start <= '0;
      r_gru_clear   <= 1'b0;
      r_vad_valid   <= 1'b0;
      if (bus.clear_state) r_pending <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (r_pending || bus.clear_state) begin
            r_state       <= S_CLR;
            r_gru_clear   <= 1'b1;
            r_frame_ready <= 1'b0;
            r_busy        <= 1'b1;
          end else if (bus.frame_valid) begin
            r_state       <= S_D1;
            r_layer_start <= layer_bit(L_DENSE1);
            r_frame_ready <= 1'b0;
            r_busy        <= 1'b1;
          end
        end
        S_CLR: begin
          r_state       <= S_IDLE;
          r_pending     <= 1'b0;
          r_frame_ready <= 1'b1;
          r_busy        <= 1'b0;
`ifdef RNN_SEQ_TIMEOUT_EN
          r_err         <= 1'b0;
`endif
        end
        S_D1: begin
          if (w_step) begin
            r_state       <= S_G1;
            r_layer_start <= layer_bit(L_GRU1);
          end
        end
        S_G1: begin
          if (w_step) begin
            r_state       <= S_PAR;
            r_layer_start <= layer_bit(L_DENSE2) | layer_bit(L_GRU2);
            r_cat_sel     <= CAT_NOISE;
            r_seen_d2     <= 1'b0;
            r_seen_g2     <= 1'b0;
          end
        end
        // dense2 and gru2 run concurrently; each done is remembered until both are in.
        S_PAR: begin
          if (w_done[L_DENSE2] && !r_seen_d2) begin
            r_vad_valid <= 1'b1;
            r_seen_d2   <= 1'b1;
          end
          if (w_done[L_GRU2]) r_seen_g2 <= 1'b1;
          if (w_step) begin
            r_state       <= S_G3;
            r_layer_start <= layer_bit(L_GRU3);
            r_cat_sel     <= CAT_DENOISE;
          end
        end
        S_G3: begin
          if (w_step) begin
            r_state       <= S_D3;
            r_layer_start <= layer_bit(L_DENSE3);
            r_cat_sel     <= CAT_NONE;
          end
        end
        S_D3: begin
          if (w_step) begin
            r_state       <= S_OUT;
            r_gains_valid <= 1'b1;
          end
        end
        S_OUT: begin
          if (bus.gains_ready) begin
            r_state       <= S_IDLE;
            r_gains_valid <= 1'b0;
            r_frame_cnt   <= r_frame_cnt + FRAME_CNT_W'(1);
            r_busy        <= 1'b0;
            r_frame_ready <= !(r_pending || bus.clear_state);
          end
        end
        default: r_state <= S_IDLE;
      endcase

`ifdef RNN_SEQ_TIMEOUT_EN
      // A done arriving on the expiry cycle still wins over the abort.
      if (w_timeout && !w_step) begin
        r_state       <= S_IDLE;
        r_err         <= 1'b1;
        r_cat_sel     <= CAT_NONE;
        r_busy        <= 1'b0;
        r_layer_start <= '0;
        r_frame_ready <= !(r_pending || bus.clear_state);
      end
`endif
    end
  end

  assign bus.frame_ready = r_frame_ready && !bus.clear_state;
  assign bus.busy        = r_busy;
  assign bus.gru_clear   = r_gru_clear;
  assign bus.vad_valid   = r_vad_valid;
  assign bus.gains_valid = r_gains_valid;
  assign bus.layer_start = r_layer_start;
  assign bus.cat_sel     = r_cat_sel;
  assign bus.frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_rnn_layer_sequencer.sv
// Directed self-checking bench for rnn_layer_sequencer; the watchdog
// section only runs when RNN_SEQ_TIMEOUT_EN is defined.
module tb_rnn_layer_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  rnn_layer_sequencer_if #(.FRAME_CNT_W(16)) bus ();

`ifdef RNN_SEQ_TIMEOUT_EN
  rnn_layer_sequencer #(
    .FRAME_CNT_W    (16),
    .TIMEOUT_CYCLES (16),
    .TIMEOUT_W      (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
`else
  rnn_layer_sequencer #(
    .FRAME_CNT_W (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs and samples both land 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic fv, input logic cs, input logic [5:0] done,
                               input logic gr);
    bus.frame_valid = fv;
    bus.clear_state = cs;
    bus.layer_done  = done;
    bus.gains_ready = gr;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Entry cycle of a layer state: check its start, answer done one cycle later.
  task automatic stepLayer(input string tag, input logic [5:0] expStart, input logic gr);
    checkOutput({tag, " start"}, 32'(bus.layer_start), 32'(expStart));
    tick();
    checkOutput({tag, " start drop"}, 32'(bus.layer_start), 32'd0);
    applyStimulus(1'b0, 1'b0, expStart, gr);
    tick();
    applyStimulus(1'b0, 1'b0, 6'd0, gr);
  endtask

  task automatic runFrameToPar(input string tag);
    applyStimulus(1'b1, 1'b0, 6'd0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b1);
    stepLayer({tag, " d1"}, 6'b000001, 1'b1);
    stepLayer({tag, " g1"}, 6'b000010, 1'b1);
    checkOutput({tag, " par start"}, 32'(bus.layer_start), 32'b001100);
    checkOutput({tag, " par cat"}, 32'(bus.cat_sel), 32'd1);
  endtask

  task automatic finishFromG3(input string tag, input int expCnt);
    checkOutput({tag, " g3 cat"}, 32'(bus.cat_sel), 32'd2);
    stepLayer({tag, " g3"}, 6'b010000, 1'b1);
    checkOutput({tag, " d3 cat"}, 32'(bus.cat_sel), 32'd0);
    stepLayer({tag, " d3"}, 6'b100000, 1'b1);
    checkOutput({tag, " gains_valid"}, 32'(bus.gains_valid), 32'd1);
    tick();
    checkOutput({tag, " gains_valid drop"}, 32'(bus.gains_valid), 32'd0);
    checkOutput({tag, " frame_cnt"}, 32'(bus.frame_cnt), 32'(expCnt));
    checkOutput({tag, " busy idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b0);
    tick();
    tick();

    checkOutput("reset frame_ready", 32'(bus.frame_ready), 32'd1);
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset layer_start", 32'(bus.layer_start), 32'd0);
    checkOutput("reset gains_valid", 32'(bus.gains_valid), 32'd0);
    checkOutput("reset frame_cnt", 32'(bus.frame_cnt), 32'd0);
    checkOutput("reset err", 32'(bus.err), 32'd0);
    checkOutput("reset cat_sel", 32'(bus.cat_sel), 32'd0);
    rst_n = 1'b1;
    tick();

    // Nominal frame with immediate dones, then 20 cycles of gains backpressure.
    applyStimulus(1'b1, 1'b0, 6'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b0);
    checkOutput("nom frame_ready", 32'(bus.frame_ready), 32'd0);
    checkOutput("nom busy", 32'(bus.busy), 32'd1);
    stepLayer("nom d1", 6'b000001, 1'b0);
    stepLayer("nom g1", 6'b000010, 1'b0);
    checkOutput("nom par cat", 32'(bus.cat_sel), 32'd1);
    stepLayer("nom par", 6'b001100, 1'b0);
    checkOutput("nom vad", 32'(bus.vad_valid), 32'd1);
    checkOutput("nom g3 cat", 32'(bus.cat_sel), 32'd2);
    stepLayer("nom g3", 6'b010000, 1'b0);
    checkOutput("nom d3 cat", 32'(bus.cat_sel), 32'd0);
    stepLayer("nom d3", 6'b100000, 1'b0);
    checkOutput("nom gains_valid T+11", 32'(bus.gains_valid), 32'd1);
    checkOutput("nom frame_cnt before", 32'(bus.frame_cnt), 32'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      checkOutput("bp gains_valid held", 32'(bus.gains_valid), 32'd1);
      checkOutput("bp frame_ready", 32'(bus.frame_ready), 32'd0);
      checkOutput("bp frame_cnt", 32'(bus.frame_cnt), 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b1);
    tick();
    checkOutput("bp gains_valid drop", 32'(bus.gains_valid), 32'd0);
    checkOutput("bp frame_cnt", 32'(bus.frame_cnt), 32'd1);
    checkOutput("bp frame_ready", 32'(bus.frame_ready), 32'd1);
    checkOutput("bp busy", 32'(bus.busy), 32'd0);

    // Spurious dones, then PAR with gru2 done 5 cycles after dense2 done.
    applyStimulus(1'b1, 1'b0, 6'd0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 6'b000001, 1'b1);
    checkOutput("spur d1 start", 32'(bus.layer_start), 32'b000001);
    tick();
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b1);
    checkOutput("spur d1 same-cycle done", 32'(bus.layer_start), 32'd0);
    tick();
    checkOutput("spur d1 still waiting", 32'(bus.layer_start), 32'd0);
    applyStimulus(1'b0, 1'b0, 6'b000001, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 6'b100010, 1'b1);
    checkOutput("spur g1 start", 32'(bus.layer_start), 32'b000010);
    tick();
    applyStimulus(1'b0, 1'b0, 6'b100000, 1'b1);
    checkOutput("spur g1 same-cycle done", 32'(bus.layer_start), 32'd0);
    tick();
    checkOutput("spur dense3 in g1", 32'(bus.layer_start), 32'd0);
    checkOutput("spur g1 cat", 32'(bus.cat_sel), 32'd0);
    applyStimulus(1'b0, 1'b0, 6'b000010, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b1);
    checkOutput("A par start", 32'(bus.layer_start), 32'b001100);
    tick();
    applyStimulus(1'b0, 1'b0, 6'b000100, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b1);
    checkOutput("A vad", 32'(bus.vad_valid), 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("A vad single", 32'(bus.vad_valid), 32'd0);
      checkOutput("A par wait", 32'(bus.layer_start), 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 6'b001000, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b1);
    finishFromG3("A", 2);

    // PAR with dense2 done 5 cycles after gru2 done.
    runFrameToPar("B");
    tick();
    applyStimulus(1'b0, 1'b0, 6'b001000, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b1);
    checkOutput("B vad early", 32'(bus.vad_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("B par wait", 32'(bus.layer_start), 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 6'b000100, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b1);
    checkOutput("B vad", 32'(bus.vad_valid), 32'd1);
    finishFromG3("B", 3);

    // PAR with simultaneous dones.
    runFrameToPar("C");
    stepLayer("C par", 6'b001100, 1'b1);
    checkOutput("C vad", 32'(bus.vad_valid), 32'd1);
    finishFromG3("C", 4);

    // clear_state during G1 is deferred until the frame finishes.
    applyStimulus(1'b1, 1'b0, 6'd0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b1);
    stepLayer("clr d1", 6'b000001, 1'b1);
    applyStimulus(1'b0, 1'b1, 6'd0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 6'b000010, 1'b1);
    checkOutput("clr no early gru_clear", 32'(bus.gru_clear), 32'd0);
    checkOutput("clr busy", 32'(bus.busy), 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b1);
    stepLayer("clr par", 6'b001100, 1'b1);
    stepLayer("clr g3", 6'b010000, 1'b1);
    stepLayer("clr d3", 6'b100000, 1'b1);
    applyStimulus(1'b1, 1'b0, 6'd0, 1'b1);
    checkOutput("clr gains_valid", 32'(bus.gains_valid), 32'd1);
    tick();
    checkOutput("clr frame_cnt", 32'(bus.frame_cnt), 32'd5);
    checkOutput("clr idle frame_ready", 32'(bus.frame_ready), 32'd0);
    checkOutput("clr idle gru_clear", 32'(bus.gru_clear), 32'd0);
    tick();
    checkOutput("clr gru_clear pulse", 32'(bus.gru_clear), 32'd1);
    checkOutput("clr busy in CLR", 32'(bus.busy), 32'd1);
    tick();
    checkOutput("clr gru_clear drop", 32'(bus.gru_clear), 32'd0);
    checkOutput("clr frame_ready", 32'(bus.frame_ready), 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b1);
    stepLayer("post d1", 6'b000001, 1'b1);
    stepLayer("post g1", 6'b000010, 1'b1);
    stepLayer("post par", 6'b001100, 1'b1);
    finishFromG3("post", 6);

`ifdef RNN_SEQ_TIMEOUT_EN
    // gru3 never answers: abort after 16 cycles in G3.
    runFrameToPar("to");
    stepLayer("to par", 6'b001100, 1'b1);
    checkOutput("to g3 start", 32'(bus.layer_start), 32'b010000);
    for (int i = 1; i < 16; i++) tick();
    checkOutput("to busy at 16th", 32'(bus.busy), 32'd1);
    checkOutput("to err at 16th", 32'(bus.err), 32'd0);
    tick();
    checkOutput("to err", 32'(bus.err), 32'd1);
    checkOutput("to busy", 32'(bus.busy), 32'd0);
    checkOutput("to frame_ready", 32'(bus.frame_ready), 32'd1);
    checkOutput("to gains_valid", 32'(bus.gains_valid), 32'd0);
    checkOutput("to frame_cnt", 32'(bus.frame_cnt), 32'd6);
    checkOutput("to cat_sel", 32'(bus.cat_sel), 32'd0);
    applyStimulus(1'b0, 1'b1, 6'd0, 1'b1);
    checkOutput("to clear frame_ready", 32'(bus.frame_ready), 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b1);
    checkOutput("to gru_clear", 32'(bus.gru_clear), 32'd1);
    tick();
    checkOutput("to err cleared", 32'(bus.err), 32'd0);
    checkOutput("to idle ready", 32'(bus.frame_ready), 32'd1);
`else
    checkOutput("err tied low", 32'(bus.err), 32'd0);
`endif

    // Reset asserted mid-frame returns to reset values immediately.
    applyStimulus(1'b1, 1'b0, 6'd0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b1);
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("midrst busy", 32'(bus.busy), 32'd0);
    checkOutput("midrst frame_ready", 32'(bus.frame_ready), 32'd1);
    checkOutput("midrst frame_cnt", 32'(bus.frame_cnt), 32'd0);
    checkOutput("midrst layer_start", 32'(bus.layer_start), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
